fp_norm_round_pack: RTL and testbench

Back end of the single-precision FP adder, the pack direction of the unpack/align/sign front end. Accepts the raw adder result: sign, aligned exponent, and an extended significand with carry, guard, round and sticky bits. Normalizes iteratively, one bit per cycle. Rounds to nearest-even. Packs an IEEE-754 binary32 word with status flags. Uses valid/ready handshakes on both sides.

---
 rtl/fp_norm_round_pack.sv | 175 +++++++++++++++++
 tb/tb_fp_norm_round_pack.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: adder back end -- one-bit-per-cycle normalisation,
// round-to-nearest-even and binary32 packing with status flags.
module fp_norm_round_pack #(
   parameter bit FLUSH_DENORM = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [27:0] in_sig,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_fp,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_sign, w_sign_nxt;
   logic [7:0]  r_exp, w_exp_nxt;
   logic [27:0] r_sig, w_sig_nxt;
   logic        r_sub, w_sub_nxt;
   logic [31:0] r_fp, w_fp_nxt;
   logic        r_ovf, w_ovf_nxt;
   logic        r_unf, w_unf_nxt;
   logic        r_inx, w_inx_nxt;

   logic        w_grs;
   logic        w_up;
   logic [24:0] w_m;
   logic [7:0]  w_exp_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_sig   <= '0;
         r_sub   <= 1'b0;
         r_fp    <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_inx   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sign  <= w_sign_nxt;
         r_exp   <= w_exp_nxt;
         r_sig   <= w_sig_nxt;
         r_sub   <= w_sub_nxt;
         r_fp    <= w_fp_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
         r_inx   <= w_inx_nxt;
      end
   end

   // Exponent never exceeds 254 here, so the increment cannot wrap.
   always_comb begin
      w_grs     = |r_sig[2:0];
      w_up      = r_sig[2] & (r_sig[3] | r_sig[1] | r_sig[0]);
      w_m       = {1'b0, r_sig[26:3]} + 25'(w_up);
      w_exp_inc = r_exp + 8'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_exp_nxt   = r_exp;
      w_sig_nxt   = r_sig;
      w_sub_nxt   = r_sub;
      w_fp_nxt    = r_fp;
      w_ovf_nxt   = r_ovf;
      w_unf_nxt   = r_unf;
      w_inx_nxt   = r_inx;

      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_sign_nxt = in_sign;
               w_exp_nxt  = (in_exp == 8'd0) ? 8'd1 : in_exp;
               w_sig_nxt  = in_sig;
               w_sub_nxt  = 1'b0;
               if (in_sig == '0) begin
                  w_state_nxt = DONE;
                  w_fp_nxt    = '0;
                  w_ovf_nxt   = 1'b0;
                  w_unf_nxt   = 1'b0;
                  w_inx_nxt   = 1'b0;
               end else if (in_exp == 8'hFF) begin
                  w_state_nxt = DONE;
                  w_fp_nxt    = {in_sign, 8'hFF, 23'h0};
                  w_ovf_nxt   = 1'b1;
                  w_unf_nxt   = 1'b0;
                  w_inx_nxt   = 1'b0;
               end else begin
                  w_state_nxt = NORM;
               end
            end
         end

         NORM: begin
            if (r_sig[27]) begin
               w_sig_nxt = {1'b0, r_sig[27:2], r_sig[1] | r_sig[0]};
               w_exp_nxt = w_exp_inc;
               if (w_exp_inc == 8'hFF) begin
                  w_state_nxt = DONE;
                  w_fp_nxt    = {r_sign, 8'hFF, 23'h0};
                  w_ovf_nxt   = 1'b1;
                  w_unf_nxt   = 1'b0;
                  w_inx_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ROUND;
               end
            end else if (r_sig[26]) begin
               w_state_nxt = ROUND;
            end else if (r_exp == 8'd1) begin
               w_sub_nxt   = 1'b1;
               w_state_nxt = ROUND;
            end else begin
               w_sig_nxt = {r_sig[26:0], 1'b0};
               w_exp_nxt = r_exp - 8'd1;
            end
         end

         ROUND: begin
            w_state_nxt = DONE;
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = r_sub & w_grs;
            w_inx_nxt   = w_grs;
            if (w_m[24]) begin
               if (w_exp_inc == 8'hFF) begin
                  w_fp_nxt  = {r_sign, 8'hFF, 23'h0};
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_fp_nxt  = {r_sign, w_exp_inc, w_m[23:1]};
               end
            end else if (r_sub) begin
               // A subnormal that rounds up into the hidden bit becomes the smallest normal.
               if (w_m[23]) begin
                  w_fp_nxt = {r_sign, 8'd1, w_m[22:0]};
               end else if (FLUSH_DENORM) begin
                  w_fp_nxt  = {r_sign, 31'h0};
                  w_unf_nxt = 1'b1;
                  w_inx_nxt = 1'b1;
               end else begin
                  w_fp_nxt = {r_sign, 8'd0, w_m[22:0]};
               end
            end else begin
               w_fp_nxt = {r_sign, r_exp, w_m[22:0]};
            end
         end

         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_fp    = r_fp;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign inexact   = r_inx;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Bench for fp_norm_round_pack: directed corner cases plus random operands,
// checked against an exact-arithmetic rounding model, on plain and flushing variants.
module tb_fp_norm_round_pack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_sig;
   logic        out_ready;

   logic        in_ready, out_valid, overflow, underflow, inexact;
   logic [31:0] out_fp;
   logic        in_ready_fz, out_valid_fz, overflow_fz, underflow_fz, inexact_fz;
   logic [31:0] out_fp_fz;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   fp_norm_round_pack #(.FLUSH_DENORM(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
      .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
      .overflow(overflow), .underflow(underflow), .inexact(inexact)
   );

   fp_norm_round_pack #(.FLUSH_DENORM(1'b1)) u_dut_fz (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_fz),
      .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
      .out_valid(out_valid_fz), .out_ready(out_ready), .out_fp(out_fp_fz),
      .overflow(overflow_fz), .underflow(underflow_fz), .inexact(inexact_fz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Result {overflow, underflow, inexact, fp}: the operand is treated as the
   // exact value sig * 2^(E-153) and rounded to the nearest binary32 quantum.
   function automatic logic [34:0] model(input logic sgn, input logic [7:0] ex,
                                         input logic [27:0] sg, input bit flush);
      int     e, p, s, field;
      longint m, q, lo, half;
      bit     inx, tiny;
      if (sg == 28'd0) return 35'd0;
      if (ex == 8'hFF) return {3'b100, sgn, 8'hFF, 23'h0};
      e = (ex == 8'd0) ? 1 : int'(ex);
      m = longint'(sg);
      p = 27;
      while (sg[p] == 1'b0) p--;
      s = (p - 23 > 4 - e) ? p - 23 : 4 - e;
      if (s <= 0) begin
         q   = m << (-s);
         inx = 1'b0;
      end else begin
         lo   = m % (longint'(1) << s);
         half = longint'(1) << (s - 1);
         q    = m >> s;
         inx  = (lo != 0);
         if (lo > half || (lo == half && q[0])) q++;
      end
      field = s + e - 3;
      if (q >= (longint'(1) << 24)) begin
         q = q >> 1;
         field++;
      end
      if (q < (longint'(1) << 23)) field = 0;
      if (field >= 255) return {3'b101, sgn, 8'hFF, 23'h0};
      tiny = (p - 23) < (4 - e);
      if (flush && field == 0) return {3'b011, sgn, 31'h0};
      return {1'b0, tiny && inx, inx, sgn, 8'(field), q[22:0]};
   endfunction

   // Clock edges from the accept edge until out_valid is visible.
   function automatic int lat_model(input logic [7:0] ex, input logic [27:0] sg);
      int e, p, sh;
      if (sg == 28'd0 || ex == 8'hFF) return 0;
      e = (ex == 8'd0) ? 1 : int'(ex);
      p = 27;
      while (sg[p] == 1'b0) p--;
      if (p == 27) return (e == 254) ? 1 : 2;
      sh = (26 - p < e - 1) ? 26 - p : e - 1;
      return sh + 2;
   endfunction

   task automatic run_txn(input logic sgn, input logic [7:0] ex, input logic [27:0] sg,
                          input int hold);
      logic [34:0] exp_r, exp_f;
      int          lat;
      exp_r = model(sgn, ex, sg, 1'b0);
      exp_f = model(sgn, ex, sg, 1'b1);
      chk("in_ready_idle", {in_ready, in_ready_fz}, 2'b11);
      in_valid = 1'b1;
      in_sign  = sgn;
      in_exp   = ex;
      in_sig   = sg;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         chk("in_ready_busy", {in_ready, in_ready_fz}, 2'b00);
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(lat_model(ex, sg)));
      if (!out_valid) return;
      chk("out_valid_fz", out_valid_fz, 1'b1);
      chk("out_fp", out_fp, exp_r[31:0]);
      chk("flags", {overflow, underflow, inexact}, exp_r[34:32]);
      chk("out_fp_fz", out_fp_fz, exp_f[31:0]);
      chk("flags_fz", {overflow_fz, underflow_fz, inexact_fz}, exp_f[34:32]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {out_valid, in_ready}, 2'b10);
         chk("hold_fp", out_fp, exp_r[31:0]);
         chk("hold_flags", {overflow, underflow, inexact}, exp_r[34:32]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release", {out_valid, in_ready, out_valid_fz, in_ready_fz}, 4'b0101);
      chk("fp_after_release", out_fp, exp_r[31:0]);
   endtask

   initial begin
      logic [7:0]  rex;
      logic [27:0] rsig;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_sig    = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hs", {in_ready, out_valid}, 2'b10);
      chk("reset_fp", out_fp, 32'h0);
      chk("reset_flags", {overflow, underflow, inexact}, 3'b000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_txn(1'b0, 8'd127, {2'b01, 1'b1, 25'h0}, 0);
      run_txn(1'b0, 8'd127, 28'h800_0000, 0);
      run_txn(1'b1, 8'd127, 28'h000_0000, 0);
      run_txn(1'b0, 8'd127, 28'h000_0008, 0);
      run_txn(1'b0, 8'd127, {1'b0, 24'hFF_FFFF, 3'b100}, 0);
      run_txn(1'b0, 8'd127, {1'b0, 24'h80_0000, 3'b100}, 0);
      run_txn(1'b0, 8'd254, 28'h800_0000, 0);
      run_txn(1'b1, 8'd254, {1'b0, 24'hFF_FFFF, 3'b110}, 0);
      run_txn(1'b0, 8'd1, 28'h200_0004, 0);
      run_txn(1'b1, 8'd0, 28'h000_0004, 0);
      run_txn(1'b0, 8'd1, {1'b0, 24'h7F_FFFF, 3'b111}, 0);
      run_txn(1'b1, 8'hFF, 28'h400_0000, 0);
      run_txn(1'b1, 8'd200, 28'h4C0_0001, 10);

      // Asynchronous reset in the middle of a long normalisation.
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_sig   = 28'h000_0008;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_hs", {out_valid, in_ready, out_valid_fz, in_ready_fz}, 4'b0101);
      chk("midreset_fp", out_fp, 32'h0);
      chk("midreset_flags", {overflow, underflow, inexact}, 3'b000);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn(1'b0, 8'd130, 28'h300_0000, 0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: rex = 8'($urandom_range(0, 5));
            3:       rex = 8'($urandom_range(248, 255));
            default: rex = 8'($urandom_range(0, 255));
         endcase
         rsig = 28'($urandom) >> $urandom_range(0, 28);
         if ($urandom_range(0, 15) == 0) rsig = '0;
         run_txn(1'($urandom), rex, rsig, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
